// File: rtl/if_fetch_queue_if.sv
// Fetch-queue to decode handshake bundle.
// The master side presents the head entry; the slave side accepts it.
interface if_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            out_valid;
  logic            deq_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc_plus4;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc_plus4,
    input  deq_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc_plus4,
    output deq_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: sequential PC, instruction ROM port, and a small
// FIFO of {instr, pc+4} entries with redirect flush.
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              IM_AW    = 6,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [IM_AW-1:0]           im_addr,
  input  logic [31:0]                im_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  if_fetch_queue_if.master           deq,
  output logic [XLEN-1:0]            fetch_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]     instrMem [DEPTH];
  logic [XLEN-1:0] pc4Mem   [DEPTH];
  logic [PW-1:0]   rdPtr;
  logic [PW-1:0]   wrPtr;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pcPlus4;
  logic            doDeq;
  logic            doPush;

  assign pcPlus4 = pc + XLEN'(4);
  assign doDeq   = deq.out_valid && deq.deq_ready
                && !redirect_valid;
  assign doPush  = !redirect_valid
                && (cnt < CW'(DEPTH) || doDeq);

  assign im_addr  = pc[IM_AW+1:2];
  assign fetch_pc = pc;
  assign count    = cnt;

  // Head fields are gated so stale array contents never leak out.
  assign deq.out_valid    = (cnt != '0);
  assign deq.out_instr    = deq.out_valid ? instrMem[rdPtr] : '0;
  assign deq.out_pc_plus4 = deq.out_valid ? pc4Mem[rdPtr]   : '0;

  always_ff @(posedge clk) begin
    if (doPush) begin
      instrMem[wrPtr] <= im_data;
      pc4Mem[wrPtr]   <= pcPlus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      cnt   <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else if (redirect_valid) begin
      pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      cnt   <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      if (doPush) begin
        pc    <= pcPlus4;
        wrPtr <= wrPtr + PW'(1);
      end
      if (doDeq)
        rdPtr <= rdPtr + PW'(1);
      unique case (1'b1)
        doPush && !doDeq: cnt <= cnt + CW'(1);
        doDeq && !doPush: cnt <= cnt - CW'(1);
        default:          cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a ROM whose word k holds k.
// Expected values are hand-computed for DEPTH=4, XLEN=32.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  imAddr;
  logic [31:0] imData;
  logic        redirValid = 1'b0;
  logic [31:0] redirPc = '0;
  logic [31:0] fetchPc;
  logic [2:0]  cnt;

  int nChecks = 0;
  int nErrors = 0;

  if_fetch_queue_if #(.XLEN(32)) q ();

  if_fetch_queue #(
    .XLEN(32), .DEPTH(4), .IM_AW(6), .RESET_PC(32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .im_addr        (imAddr),
    .im_data        (imData),
    .redirect_valid (redirValid),
    .redirect_pc    (redirPc),
    .deq            (q),
    .fetch_pc       (fetchPc),
    .count          (cnt)
  );

  assign imData = {26'd0, imAddr};

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic head(
    input string       tag,
    input logic [31:0] ins,
    input logic [31:0] p4
  );
    chk({tag, ".valid"}, 32'(q.out_valid), 32'd1);
    chk({tag, ".instr"}, q.out_instr, ins);
    chk({tag, ".pc4"},   q.out_pc_plus4, p4);
  endtask

  task automatic doReset();
    #1;
    rst = 1'b1;
    #1;
    chk("rst.count", 32'(cnt), 32'd0);
    chk("rst.valid", 32'(q.out_valid), 32'd0);
    chk("rst.instr", q.out_instr, 32'd0);
    chk("rst.pc4",   q.out_pc_plus4, 32'd0);
    chk("rst.pc",    fetchPc, 32'd0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    q.deq_ready = 1'b1;
    step();

    // streaming with decode always ready
    doReset();
    step();
    head("s1.h0", 32'd0, 32'd4);
    chk("s1.cnt0", 32'(cnt), 32'd1);
    step();
    head("s1.h1", 32'd1, 32'd8);
    step();
    head("s1.h2", 32'd2, 32'd12);
    chk("s1.pc", fetchPc, 32'd12);

    // mid-run reset, then stall until full
    q.deq_ready = 1'b0;
    doReset();
    for (int i = 0; i < 10; i++) step();
    chk("s2.cnt", 32'(cnt), 32'd4);
    chk("s2.pc", fetchPc, 32'h10);
    head("s2.h", 32'd0, 32'd4);

    // one cycle of deq while full
    q.deq_ready = 1'b1;
    step();
    q.deq_ready = 1'b0;
    chk("s3.cnt", 32'(cnt), 32'd4);
    chk("s3.pc", fetchPc, 32'h14);
    head("s3.h", 32'd1, 32'd8);

    // redirect with three entries queued
    doReset();
    step(); step(); step();
    chk("s4.cnt3", 32'(cnt), 32'd3);
    redirValid = 1'b1;
    redirPc    = 32'h23;
    step();
    redirValid = 1'b0;
    chk("s4.cnt", 32'(cnt), 32'd0);
    chk("s4.valid", 32'(q.out_valid), 32'd0);
    chk("s4.pc", fetchPc, 32'h20);
    chk("s4.addr", 32'(imAddr), 32'd8);
    step();
    head("s4.h", 32'd8, 32'h24);

    // redirect beats deq while full
    step(); step(); step();
    chk("s5.cnt4", 32'(cnt), 32'd4);
    redirValid  = 1'b1;
    redirPc     = 32'h40;
    q.deq_ready = 1'b1;
    step();
    redirValid  = 1'b0;
    q.deq_ready = 1'b0;
    chk("s5.cnt", 32'(cnt), 32'd0);
    chk("s5.valid", 32'(q.out_valid), 32'd0);
    chk("s5.instr", q.out_instr, 32'd0);
    chk("s5.pc", fetchPc, 32'h40);

    // PC wrap at top of address space
    redirValid = 1'b1;
    redirPc    = 32'hFFFF_FFFF;
    step();
    redirValid = 1'b0;
    chk("s6.pc0", fetchPc, 32'hFFFF_FFFC);
    step();
    chk("s6.pc", fetchPc, 32'h0);
    chk("s6.cnt", 32'(cnt), 32'd1);
    head("s6.h", 32'd63, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             nChecks, nErrors);
    $finish;
  end

endmodule
